data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Byte-addressed little-endian data memory behind a valid/ready request/response handshake.
// Requests wait LATENCY cycles, then one response is held until rsp_ready.
module data_mem_responder #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic                  we_q;
    logic [DM_ADDRESS-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [2:0]            funct3_q;

    logic [7:0] mem [2**DM_ADDRESS];

    logic                  accept;
    logic                  enter_resp;
    logic                  cur_we;
    logic [DM_ADDRESS-1:0] cur_addr;
    logic [31:0]           cur_wdata;
    logic [2:0]            cur_funct3;
    logic [DM_ADDRESS-3:0] word_idx;

    logic              fn_ok;
    logic              misalign;
    logic              err;
    logic [31:0]       rd_word;
    logic [31:0]       rd_shift;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic [3:0]        be;
    logic [31:0]       st_lane;
    logic              mem_we;

    // While idle the live request is the operand source so LATENCY=0 can respond at accept.
    always_comb begin
        accept     = (state_q == StIdle) && req_valid;
        enter_resp = (accept && (LATENCY == 0)) || ((state_q == StWait) && (cnt_q == 4'd0));
        if (state_q == StIdle) begin
            cur_we     = req_we;
            cur_addr   = req_addr;
            cur_wdata  = req_wdata[31:0];
            cur_funct3 = req_funct3;
        end else begin
            cur_we     = we_q;
            cur_addr   = addr_q;
            cur_wdata  = wdata_q;
            cur_funct3 = funct3_q;
        end
        word_idx = cur_addr[DM_ADDRESS-1:2];
    end

    always_comb begin
        fn_ok = 1'b0;
        case (cur_funct3)
            3'b000, 3'b001, 3'b010: fn_ok = 1'b1;
            3'b100, 3'b101:         fn_ok = !cur_we;
            default:                fn_ok = 1'b0;
        endcase
        misalign = ((cur_funct3[1:0] == 2'b01) && cur_addr[0]) ||
                   ((cur_funct3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
        err = !fn_ok || misalign;
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < 4; k++) begin
            rd_word[8*k +: 8] = mem[{word_idx, 2'(k)}];
        end
        rd_shift = rd_word >> {cur_addr[1:0], 3'b000};
        case (cur_funct3)
            3'b000:  load_data = {{(DATA_W-8){rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_data = {{(DATA_W-16){rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  load_data = DATA_W'(rd_word);
            3'b100:  load_data = DATA_W'(rd_shift[7:0]);
            3'b101:  load_data = DATA_W'(rd_shift[15:0]);
            default: load_data = '0;
        endcase
        rsp_rdata_d = (err || cur_we) ? '0 : load_data;
    end

    always_comb begin
        case (cur_funct3[1:0])
            2'b00:   be = 4'b0001 << cur_addr[1:0];
            2'b01:   be = 4'b0011 << cur_addr[1:0];
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        st_lane = cur_wdata << {cur_addr[1:0], 3'b000};
        mem_we  = !reset && enter_resp && cur_we && !err;
    end

    // Memory has no reset so its contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[{word_idx, 2'(k)}] <= st_lane[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            we_q     <= req_we;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata[31:0];
            funct3_q <= req_funct3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (LATENCY == 0) begin
                            state_q   <= StResp;
                            rsp_valid <= 1'b1;
                            rsp_err   <= err;
                            rsp_rdata <= rsp_rdata_d;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= 4'(LATENCY - 1);
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q   <= StResp;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err;
                        rsp_rdata <= rsp_rdata_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q   <= StIdle;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
